// File: rtl/pu_output_drain.sv
// Walks the processing-unit output buffers (channel, row, column-word) and streams each word out
// over valid/ready with a linear address. Optional macro DRAIN_STALL_CNT_EN adds o_stall_cycles.
module pu_output_drain #(
  parameter int OUTPUT_CHANNEL  = 4,
  parameter int OUTPUT_HEIGHT   = 2,
  parameter int OUTPUT_WIDTH    = 4,
  parameter int OUTPUT_SRAM_LEN = 4,
  parameter int BIN_LEN         = 8,
  parameter int RD_LAT          = 1,
  localparam int CW = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1,
  localparam int HW = (OUTPUT_HEIGHT > 1) ? $clog2(OUTPUT_HEIGHT) : 1,
  localparam int WW = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1,
  localparam int DW = BIN_LEN * OUTPUT_SRAM_LEN
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [CW-1:0]             i_oc_last,
  input  logic [31:0]               i_base_address,
  output logic [OUTPUT_CHANNEL-1:0] o_ob_r_enable,
  output logic [HW-1:0]             o_ob_sram_r_out,
  output logic [WW-1:0]             o_ob_sram_c_out,
  input  logic [DW-1:0]             i_ob_sram_out,
  output logic [DW-1:0]             o_out_data,
  output logic [31:0]               o_out_address,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic                      o_busy,
  output logic                      o_done
`ifdef DRAIN_STALL_CNT_EN
  ,
  output logic [31:0]               o_stall_cycles
`endif
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_SEND, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_oc, r_oc_last;
  logic [HW-1:0] r_row;
  logic [WW-1:0] r_col;
  logic [LW-1:0] r_lat;
  logic [31:0]   r_base, r_idx;
  logic [DW-1:0] r_data;

  logic w_start_ok, w_hs, w_row_end, w_last, w_lat_end;

  // DONE also accepts a new start since busy is already low there.
  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_hs       = (r_state == S_SEND) && i_out_ready;
  assign w_row_end  = (int'(r_col) + OUTPUT_SRAM_LEN >= OUTPUT_WIDTH);
  assign w_last     = (r_oc == r_oc_last) && (int'(r_row) == OUTPUT_HEIGHT - 1) && w_row_end;
  assign w_lat_end  = (int'(r_lat) == RD_LAT - 1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_READ;
      S_READ: if (w_lat_end) w_next = S_CAPT;
      S_CAPT: w_next = S_SEND;
      S_SEND: if (i_out_ready) w_next = w_last ? S_DONE : S_READ;
      S_DONE: w_next = w_start_ok ? S_READ : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_oc      <= '0;
      r_oc_last <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_lat     <= '0;
      r_base    <= '0;
      r_idx     <= '0;
      r_data    <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_oc      <= '0;
        r_row     <= '0;
        r_col     <= '0;
        r_lat     <= '0;
        r_idx     <= '0;
        r_base    <= i_base_address;
        r_oc_last <= (int'(i_oc_last) > OUTPUT_CHANNEL - 1) ? CW'(OUTPUT_CHANNEL - 1) : i_oc_last;
      end
      if (r_state == S_READ) r_lat <= w_lat_end ? '0 : r_lat + LW'(1);
      if (r_state == S_CAPT) r_data <= i_ob_sram_out;
      // The last word leaves the counters on its own position so r/c outputs hold.
      if (w_hs && !w_last) begin
        r_idx <= r_idx + 32'd1;
        if (w_row_end) begin
          r_col <= '0;
          if (int'(r_row) == OUTPUT_HEIGHT - 1) begin
            r_row <= '0;
            r_oc  <= r_oc + CW'(1);
          end else begin
            r_row <= r_row + HW'(1);
          end
        end else begin
          r_col <= r_col + WW'(OUTPUT_SRAM_LEN);
        end
      end
    end
  end

`ifdef DRAIN_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_stall <= '0;
    else if (w_start_ok)
      r_stall <= '0;
    else if (r_state == S_SEND && !i_out_ready && r_stall != 32'hFFFF_FFFF)
      r_stall <= r_stall + 32'd1;
  end
  assign o_stall_cycles = r_stall;
`endif

  assign o_ob_r_enable   = (r_state == S_READ) ? (OUTPUT_CHANNEL'(1) << r_oc) : '0;
  assign o_ob_sram_r_out = r_row;
  assign o_ob_sram_c_out = r_col;
  assign o_out_data      = r_data;
  assign o_out_address   = r_base + r_idx;
  assign o_out_valid     = (r_state == S_SEND);
  assign o_busy          = (r_state == S_READ) || (r_state == S_CAPT) || (r_state == S_SEND);
  assign o_done          = (r_state == S_DONE);

endmodule
